data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-port arbiter that shares the single DataMem port (9-bit word index, Address[10:2]; combinational read; write on posedge Clk) between the processor data path (port 0) and a debug/DMA loader (port 1). Each cycle it grants at most one requester, drives MemRead/MemWrite/Address/WriteData toward DataMem, and returns a registered read response with an error flag. Arbitration is round-robin, with an optional bounded lock for back-to-back bursts. The block sits between the requesters and DataMem in the top level.

## Interface
- MAX_LOCK, default 8: maximum consecutive grants to one locking requester while the other port is requesting.
- ADDR_BITS, default 11: byte-address bits that map into DataMem. Any set bit in Address[31:ADDR_BITS] is out of range.
- Clk  input  1  clock. All state updates on posedge.
- Rst  input  1  synchronous, active-high reset.
- Req0, Req1  input  1  access request, one per port.
- Wr0, Wr1  input  1  1 = write, 0 = read. Valid while Req is high.
- Lock0, Lock1  input  1  request to keep the grant on the next cycle.
- Addr0, Addr1  input  32  byte address.
- WData0, WData1  input  32  write data.
- Gnt0, Gnt1  output  1  combinational grant, same cycle as Req. One-hot or zero.
- RValid0, RValid1  output  1  registered read or error response, one cycle after a granted read.
- RData  output  32  registered read data, shared by both ports. Qualified by RValid0 or RValid1.
- Err  output  1  registered. Set together with RValid for an out-of-range access.
- MemRead, MemWrite  output  1  drive DataMem.
- MemAddress, MemWriteData  output  32  drive DataMem.
- MemReadData  input  32  DataMem ReadData.

## Operation
- State:
  - Last: last-granted port, 1 bit.
  - Owner: locking port, valid flag plus id.
  - LockCnt: counter, clog2(MAX_LOCK+1) bits.
  - Response registers.
- Winner selection, in priority order:
  - If the owner is valid, that port's Req is high, and LockCnt < MAX_LOCK, the owner wins.
  - Otherwise, if only one port requests, that port wins.
  - Otherwise, with both requesting, the port != Last wins.
- On a grant:
  - Last <= winner.
  - If Lock(winner) is high: Owner <= winner, and LockCnt <= LockCnt+1 when the previous owner was the same port, else LockCnt <= 1.
  - If Lock(winner) is low: Owner <= invalid, LockCnt <= 0.
- Forced release: when LockCnt == MAX_LOCK and the other port requests, the other port wins. The lock then clears.
  - If the other port is idle, the owner keeps winning and LockCnt saturates at MAX_LOCK.
- Owner deasserts Req: Owner is invalidated, LockCnt <= 0, and normal round-robin applies that cycle.
- Memory mapping:
  - MemAddress = winner Addr and MemWriteData = winner WData, passed through unchanged.
  - MemRead = grant & ~Wr & in-range.
  - MemWrite = grant & Wr & in-range.
  - No grant: all Mem* outputs are 0.
- Out-of-range access: the memory is not touched (MemRead and MemWrite stay 0).
  - Next cycle: RValid(winner)=1, Err=1, RData=0.
  - This applies to writes too: an out-of-range write produces a one-cycle RValid with Err=1.
- In-range read: next cycle RValid(winner)=1, RData = the captured MemReadData, Err=0.
- In-range write: no response. RValid stays 0.
- Ungranted requests must hold Req, Wr, Addr and WData until granted. The arbiter does not queue requests.

## Timing
- Grant latency: 0 cycles (combinational).
- Read data latency: 1 cycle after the grant cycle.
- A write commits at the posedge that ends the grant cycle.
- Read-after-write by either port in the next cycle returns the new data.
- Throughput: one access per cycle, sustained.
- Reset (Rst=1 at posedge):
  - Last=1, so port 0 wins first.
  - Owner invalid, LockCnt=0.
  - RValid0=RValid1=0, RData=0, Err=0.
- During Rst, Gnt0, Gnt1, MemRead and MemWrite are forced to 0.
- Rst asserted in the cycle after a granted read: that response is dropped.
- Simultaneous first requests after reset: port 0 is granted.

## Structure
- Package data_mem_arb_pkg holds:
  - NUM_PORTS = 2.
  - DMEM_WORDS = 512.
  - A typedef for the port id.
  - A packed struct mem_req_t {wr, addr, wdata}.
  - Function in_range(addr, ADDR_BITS).
- Sub-module rr_lock_sel: takes the Req vector, Last, Owner and LockCnt, and produces the one-hot grant and next-state values.
- The top module muxes requests to the memory and registers responses.

## Test plan
- Reset, then Req0 read of Addr0=0x7D0 with regMem[500] preloaded 0xA5A5A5A5 -> Gnt0=1 in the same cycle, MemRead=1 with MemAddress=0x7D0; next cycle RValid0=1, RData=0xA5A5A5A5, Err=0.
- Req0 and Req1 both held high for 4 cycles, no Lock -> grants alternate 0,1,0,1.
- Port 1 writes 0x12345678 to Addr 0x7D4, then port 0 reads 0x7D4 in the next cycle -> RData=0x12345678.
- Port 1 holds Lock1 with MAX_LOCK=8 while Req0 is held high -> 8 consecutive Gnt1, then Gnt0.
  - Repeat with Req0 low: Gnt1 continues indefinitely.
- Port 0 reads Addr0=0x00000800 -> MemRead=0 and MemWrite=0; next cycle RValid0=1, Err=1, RData=0.
- Rst asserted in the cycle after a granted read -> no RValid, all outputs 0. First simultaneous requests after reset are granted to port 0.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for the DataMem arbiter and its round-robin/lock selector.
package data_mem_arb_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned DMEM_WORDS = 512;

    typedef logic port_id_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // An address maps into DataMem only if no bit at or above addr_bits is set.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned addr_bits);
        return (addr >> addr_bits) == 32'd0;
    endfunction

endpackage

// File: rtl/rr_lock_sel.sv
// Round-robin winner selection with a bounded lock; purely combinational, the caller
// holds the state registers and applies the returned next-state values.
module rr_lock_sel
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_LOCK = 8,
    parameter int unsigned CNT_W    = $clog2(MAX_LOCK + 1)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] lock_i,
    input  port_id_t             last_i,
    input  logic                 owner_valid_i,
    input  port_id_t             owner_id_i,
    input  logic [CNT_W-1:0]     lock_cnt_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output port_id_t             winner_o,
    output port_id_t             last_d_o,
    output logic                 owner_valid_d_o,
    output port_id_t             owner_id_d_o,
    output logic [CNT_W-1:0]     lock_cnt_d_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    logic any_req;
    assign any_req = |req_i;

    always_comb begin
        winner_o = ~last_i;
        if (owner_valid_i && req_i[owner_id_i] && (lock_cnt_i < MAX_CNT)) begin
            winner_o = owner_id_i;
        end else if (req_i == 2'b01) begin
            winner_o = 1'b0;
        end else if (req_i == 2'b10) begin
            winner_o = 1'b1;
        end
        gnt_o = any_req ? (NUM_PORTS'(1) << winner_o) : '0;
    end

    // With no grant the owner has necessarily dropped Req, so the lock is released.
    always_comb begin
        last_d_o        = last_i;
        owner_valid_d_o = 1'b0;
        owner_id_d_o    = owner_id_i;
        lock_cnt_d_o    = '0;
        if (any_req) begin
            last_d_o = winner_o;
            if (lock_i[winner_o]) begin
                owner_valid_d_o = 1'b1;
                owner_id_d_o    = winner_o;
                if (owner_valid_i && (owner_id_i == winner_o)) begin
                    lock_cnt_d_o = (lock_cnt_i == MAX_CNT) ? MAX_CNT : lock_cnt_i + CNT_W'(1);
                end else begin
                    lock_cnt_d_o = CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the DataMem port between the data path (port 0) and the debug/DMA loader (port 1),
// granting combinationally and returning a registered read/error response.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_LOCK  = 8,
    parameter int unsigned ADDR_BITS = 11
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        Wr0,
    input  logic        Wr1,
    input  logic        Lock0,
    input  logic        Lock1,
    input  logic [31:0] Addr0,
    input  logic [31:0] Addr1,
    input  logic [31:0] WData0,
    input  logic [31:0] WData1,
    output logic        Gnt0,
    output logic        Gnt1,
    output logic        RValid0,
    output logic        RValid1,
    output logic [31:0] RData,
    output logic        Err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    logic [NUM_PORTS-1:0] req, lock, gnt, rvalid_q;
    port_id_t             last_q, last_d, owner_id_q, owner_id_d, winner;
    logic                 owner_valid_q, owner_valid_d;
    logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
    mem_req_t             req_bus [NUM_PORTS];
    mem_req_t             sel;
    logic                 granted, sel_in_range;
    logic [31:0]          rdata_q;
    logic                 err_q;

    // Masking requests during reset keeps every grant and memory strobe low.
    assign req  = {Req1, Req0} & {NUM_PORTS{~Rst}};
    assign lock = {Lock1, Lock0};

    rr_lock_sel #(
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) u_sel (
        .req_i           (req),
        .lock_i          (lock),
        .last_i          (last_q),
        .owner_valid_i   (owner_valid_q),
        .owner_id_i      (owner_id_q),
        .lock_cnt_i      (lock_cnt_q),
        .gnt_o           (gnt),
        .winner_o        (winner),
        .last_d_o        (last_d),
        .owner_valid_d_o (owner_valid_d),
        .owner_id_d_o    (owner_id_d),
        .lock_cnt_d_o    (lock_cnt_d)
    );

    assign req_bus[0]   = '{wr: Wr0, addr: Addr0, wdata: WData0};
    assign req_bus[1]   = '{wr: Wr1, addr: Addr1, wdata: WData1};
    assign sel          = req_bus[winner];
    assign granted      = |gnt;
    assign sel_in_range = in_range(sel.addr, ADDR_BITS);

    assign Gnt0         = gnt[0];
    assign Gnt1         = gnt[1];
    assign MemRead      = granted & ~sel.wr & sel_in_range;
    assign MemWrite     = granted & sel.wr & sel_in_range;
    assign MemAddress   = granted ? sel.addr : '0;
    assign MemWriteData = granted ? sel.wdata : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_q        <= 1'b1;
            owner_valid_q <= 1'b0;
            owner_id_q    <= 1'b0;
            lock_cnt_q    <= '0;
        end else begin
            last_q        <= last_d;
            owner_valid_q <= owner_valid_d;
            owner_id_q    <= owner_id_d;
            lock_cnt_q    <= lock_cnt_d;
        end
    end

    // Reads and out-of-range accesses of either kind answer; in-range writes are silent.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= '0;
            err_q    <= 1'b0;
            if (granted && (!sel.wr || !sel_in_range)) begin
                rvalid_q[winner] <= 1'b1;
                err_q            <= ~sel_in_range;
                rdata_q          <= sel_in_range ? MemReadData : '0;
            end
        end
    end

    // A response still in flight when reset arrives is suppressed immediately.
    assign RValid0 = rvalid_q[0] & ~Rst;
    assign RValid1 = rvalid_q[1] & ~Rst;
    assign Err     = err_q & ~Rst;
    assign RData   = Rst ? '0 : rdata_q;

endmodule
